// File: rtl/pcpi_nibble_sequencer_pkg.sv
// pcpi_seq_pkg: shared state encoding and widths for the PCPI nibble sequencer
package pcpi_seq_pkg;
  typedef enum logic [2:0] {LOAD_WAIT, LOAD_REL, ISSUE, OUT_SHOW, OUT_REL} state_e;
  localparam int NIBBLES = 8;
  localparam int NIB_W = 4;
  localparam int INSN_W = 32;
  localparam int CNT_W = 3;
  localparam int TMO_W = 8;
endpackage

// File: rtl/pcpi_nibble_sequencer_if.sv
// pcpi_nibble_sequencer_if: host nibble handshakes, PCPI bus and status lines
interface pcpi_nibble_sequencer_if;
  import pcpi_seq_pkg::*;
  logic nib_valid;
  logic [NIB_W-1:0] nib_data;
  logic nib_ack;
  logic res_valid;
  logic [NIB_W-1:0] res_data;
  logic res_ack;
  logic pcpi_valid;
  logic [INSN_W-1:0] pcpi_insn;
  logic pcpi_ready;
  logic pcpi_wr;
  logic pcpi_wait;
  logic [INSN_W-1:0] pcpi_rd;
  logic busy;
  logic done;
  logic err;
  modport slave (
    input nib_valid, nib_data, res_ack, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
    output nib_ack, res_valid, res_data, pcpi_valid, pcpi_insn, busy, done, err
  );
  modport master (
    output nib_valid, nib_data, res_ack, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
    input nib_ack, res_valid, res_data, pcpi_valid, pcpi_insn, busy, done, err
  );
endinterface

// File: rtl/pcpi_nibble_sequencer_bit_sync.sv
// bit_sync: multi-flop synchronizer for an asynchronous single-bit input
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  // shift the raw input through the flop chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pcpi_nibble_sequencer.sv
// pcpi_nibble_sequencer: nibble-serial host bridge that issues and retires PCPI instructions
module pcpi_nibble_sequencer
  import pcpi_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  pcpi_nibble_sequencer_if.slave bus
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [INSN_W-1:0] insn_q, insn_d, sh_q, sh_d;
  logic ack_q, ack_d, pv_q, pv_d, rv_q, rv_d, done_q, done_d, err_q, err_d;
  logic nv_s, ra_s;
  bit_sync #(.STAGES(SYNC_STAGES)) u_nv_sync (.clk(clk), .rst_n(rst_n), .d_i(bus.nib_valid), .q_o(nv_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_ra_sync (.clk(clk), .rst_n(rst_n), .d_i(bus.res_ack), .q_o(ra_s));
  assign bus.nib_ack = ack_q;
  assign bus.pcpi_valid = pv_q;
  assign bus.pcpi_insn = insn_q;
  assign bus.res_valid = rv_q;
  assign bus.res_data = sh_q[NIB_W-1:0];
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.busy = !(state_q == LOAD_WAIT && cnt_q == '0);
  // state and datapath registers; reset discards any partial transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD_WAIT;
      cnt_q <= '0;
      tmo_q <= '0;
      insn_q <= '0;
      sh_q <= '0;
      ack_q <= 1'b0;
      pv_q <= 1'b0;
      rv_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      insn_q <= insn_d;
      sh_q <= sh_d;
      ack_q <= ack_d;
      pv_q <= pv_d;
      rv_q <= rv_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  // load, issue with watchdog, and result unload sequencing
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    insn_d = insn_q;
    sh_d = sh_q;
    ack_d = ack_q;
    pv_d = pv_q;
    rv_d = rv_q;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      LOAD_WAIT: if (nv_s) begin
        insn_d[{cnt_q, 2'b00} +: NIB_W] = bus.nib_data;
        ack_d = 1'b1;
        err_d = (cnt_q == '0) ? 1'b0 : err_q;
        state_d = LOAD_REL;
      end
      LOAD_REL: if (!nv_s) begin
        ack_d = 1'b0;
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? ISSUE : LOAD_WAIT;
        pv_d = (cnt_q == CNT_LAST);
        tmo_d = '0;
      end
      ISSUE: begin
        tmo_d = bus.pcpi_wait ? '0 : tmo_q + 1'b1;
        if (bus.pcpi_ready) begin
          pv_d = 1'b0;
          sh_d = bus.pcpi_wr ? bus.pcpi_rd : sh_q;
          rv_d = bus.pcpi_wr;
          done_d = !bus.pcpi_wr;
          state_d = bus.pcpi_wr ? OUT_SHOW : LOAD_WAIT;
        end else if (!bus.pcpi_wait && tmo_q == TMO_LAST) begin
          pv_d = 1'b0;
          err_d = 1'b1;
          done_d = 1'b1;
          state_d = LOAD_WAIT;
        end
      end
      OUT_SHOW: if (ra_s) begin
        rv_d = 1'b0;
        state_d = OUT_REL;
      end
      OUT_REL: if (!ra_s) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        done_d = (cnt_q == CNT_LAST);
        sh_d = (cnt_q == CNT_LAST) ? sh_q : sh_q >> NIB_W;
        rv_d = (cnt_q != CNT_LAST);
        state_d = (cnt_q == CNT_LAST) ? LOAD_WAIT : OUT_SHOW;
      end
      default: state_d = LOAD_WAIT;
    endcase
  end
endmodule

// File: tb/tb_pcpi_nibble_sequencer.sv
// tb_pcpi_nibble_sequencer: directed self-checking bench for the PCPI nibble sequencer
module tb_pcpi_nibble_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errs = 0;
  int checks = 0;
  int dones = 0;
  always #5 clk = ~clk;
  pcpi_nibble_sequencer_if bus();
  pcpi_nibble_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  // count done pulses as seen at sampling points
  always @(negedge clk) if (bus.done === 1'b1) dones++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic sig(input int w);
    case (w)
      0: return bus.nib_ack;
      1: return bus.pcpi_valid;
      2: return bus.res_valid;
      default: return bus.done;
    endcase
  endfunction
  task automatic wait_sig(input string tag, input int w, input logic v, output int n);
    n = 0;
    while (sig(w) !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errs++;
      $error("FAIL %s: observed timeout expected level %0b", tag, v);
    end
  endtask
  task automatic send_nibble(input logic [3:0] d, output int lat);
    int n;
    @(negedge clk);
    bus.nib_data = d;
    bus.nib_valid = 1'b1;
    wait_sig("ack_rise", 0, 1'b1, lat);
    bus.nib_valid = 1'b0;
    wait_sig("ack_fall", 0, 1'b0, n);
  endtask
  task automatic load(input logic [31:0] w, input int from);
    int lat;
    for (int i = from; i < 8; i++) send_nibble(w[4*i +: 4], lat);
  endtask
  task automatic respond(input logic wr, input logic [31:0] rd);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr = wr;
    bus.pcpi_rd = rd;
    @(negedge clk);
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr = 1'b0;
  endtask
  initial begin
    int lat, n, d0;
    logic [31:0] w;
    bus.nib_valid = 1'b0;
    bus.nib_data = '0;
    bus.res_ack = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr = 1'b0;
    bus.pcpi_wait = 1'b0;
    bus.pcpi_rd = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack", bus.nib_ack, 0);
    chk("rst_pv", bus.pcpi_valid, 0);
    chk("rst_rv", bus.res_valid, 0);
    chk("rst_insn", bus.pcpi_insn, 0);
    chk("rst_rdata", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w = 32'h1234ABCD;
    send_nibble(w[3:0], lat);
    chk("ack_latency", lat, 3);
    chk("busy_loading", bus.busy, 1);
    for (int i = 1; i < 7; i++) send_nibble(w[4*i +: 4], lat);
    chk("pv_before_last", bus.pcpi_valid, 0);
    send_nibble(w[31:28], lat);
    chk("pv_issue", bus.pcpi_valid, 1);
    chk("insn", bus.pcpi_insn, 32'h1234ABCD);
    bus.pcpi_wait = 1'b1;
    repeat (200) @(negedge clk);
    chk("pv_held_wait", bus.pcpi_valid, 1);
    chk("err_wait", bus.err, 0);
    bus.pcpi_wait = 1'b0;
    respond(1'b1, 32'hCAFEF00D);
    chk("pv_drop", bus.pcpi_valid, 0);
    chk("rv_first", bus.res_valid, 1);
    chk("err_ok", bus.err, 0);
    w = 32'hCAFEF00D;
    d0 = dones;
    for (int i = 0; i < 8; i++) begin
      wait_sig("rv_rise", 2, 1'b1, n);
      chk($sformatf("res_nib%0d", i), bus.res_data, w[4*i +: 4]);
      if (i == 7) chk("no_early_done", dones, d0);
      @(negedge clk);
      bus.res_ack = 1'b1;
      wait_sig("rv_fall", 2, 1'b0, n);
      @(negedge clk);
      bus.res_ack = 1'b0;
    end
    wait_sig("done_rise", 3, 1'b1, n);
    @(negedge clk);
    chk("done_once", dones, d0 + 1);
    chk("done_pulse", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    load(32'h0F0F0F0F, 0);
    d0 = dones;
    n = 0;
    while (bus.pcpi_valid === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_len", n, 64);
    chk("tmo_err", bus.err, 1);
    chk("tmo_busy", bus.busy, 0);
    @(negedge clk);
    chk("tmo_done", dones, d0 + 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", bus.err, 1);
    w = 32'h87654325;
    send_nibble(w[3:0], lat);
    chk("err_clear", bus.err, 0);
    load(w, 1);
    chk("insn2", bus.pcpi_insn, w);
    d0 = dones;
    respond(1'b0, 32'hFFFFFFFF);
    chk("nowr_pv", bus.pcpi_valid, 0);
    chk("nowr_rv", bus.res_valid, 0);
    chk("nowr_busy", bus.busy, 0);
    @(negedge clk);
    chk("nowr_done", dones, d0 + 1);
    chk("nowr_rv2", bus.res_valid, 0);
    w = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) send_nibble(w[4*i +: 4], lat);
    @(negedge clk);
    bus.nib_valid = 1'b1;
    wait_sig("ack_rise4", 0, 1'b1, n);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", bus.nib_ack, 0);
    chk("mid_rst_insn", bus.pcpi_insn, 0);
    chk("mid_rst_busy", bus.busy, 0);
    bus.nib_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load(32'h00000001, 0);
    chk("post_rst_insn", bus.pcpi_insn, 32'h00000001);
    chk("post_rst_pv", bus.pcpi_valid, 1);
    respond(1'b1, 32'h12345678);
    chk("show_rv", bus.res_valid, 1);
    chk("show_nib", bus.res_data, 4'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("show_rst_rv", bus.res_valid, 0);
    chk("show_rst_rdata", bus.res_data, 0);
    chk("show_rst_pv", bus.pcpi_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(32'hDEADBEEF, 0);
    repeat (63) @(negedge clk);
    chk("edge_pv_held", bus.pcpi_valid, 1);
    respond(1'b0, 32'h0);
    chk("edge_pv", bus.pcpi_valid, 0);
    chk("edge_err", bus.err, 0);
    chk("edge_done", bus.done, 1);
    @(negedge clk);
    chk("edge_done_pulse", bus.done, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
